// File: rtl/shift_right_seq.sv
// shift_right_seq: iterative log-stage right shifter (SRL/SRA) behind valid/ready
module shift_right_seq #(
  parameter int data_length = 32
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic                           IR,
  input  logic [$clog2(data_length)-1:0] shift,
  input  logic [data_length-1:0]         B,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [data_length-1:0]         H
);
  localparam int N = $clog2(data_length);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t                 r_state, w_next;
  logic [data_length-1:0] r_data, w_shifted;
  logic [N-1:0]           r_amt, r_stg;
  logic                   r_fill, w_last, w_bit;
  logic [N:0]             w_step;
  assign w_step    = (N+1)'(1) << r_stg;
  assign w_shifted = (r_data >> w_step) | ({data_length{r_fill}} & ~({data_length{1'b1}} >> w_step));
  assign w_bit     = |(r_amt & (N'(1) << r_stg));
  assign w_last    = r_stg == N'(N-1);
  assign H         = r_data;
  // state register
  always_ff @(posedge clk) r_state <= rst ? IDLE : w_next;
  // next state and handshake outputs, which depend only on state and rst
  always_comb begin
    w_next    = r_state;
    in_ready  = r_state == IDLE && !rst;
    out_valid = r_state == DONE;
    w_next    = (r_state == IDLE && in_valid) ? SHIFT :
                (r_state == SHIFT && w_last)  ? DONE  :
                (r_state == DONE && out_ready) ? IDLE : r_state;
  end
  // operand capture on accept, then one power-of-two stage per SHIFT cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      r_data <= '0;
      r_amt  <= '0;
      r_fill <= 1'b0;
      r_stg  <= '0;
    end else if (r_state == IDLE && in_valid) begin
      r_data <= B;
      r_amt  <= shift;
      r_fill <= IR;
      r_stg  <= '0;
    end else if (r_state == SHIFT) begin
      if (w_bit) r_data <= w_shifted;
      r_stg <= w_last ? r_stg : r_stg + 1'b1;
    end
  end
endmodule

// File: doc/shift_right_seq.md
# shift_right_seq

Iterative logarithmic right shifter that complements the combinational `shift_left` barrel shifter. It implements RV32I SRL and SRA, plus their immediate forms, as a multi-cycle unit behind a valid/ready handshake. It applies one power-of-two stage per clock, so a full shift completes in `$clog2(data_length)` cycles. It sits beside the ALU datapath and is used where a single-cycle barrel shifter would not close timing.

## Interface
Parameters:
- `data_length`, default 32, operand/result width; must be a power of two ≥ 4. Define N = `$clog2(data_length)`.

Ports:
- `clk`  input  1  system clock; all state updates on its rising edge.
- `rst`  input  1  reset, synchronous, active-high.
- `in_valid`  input  1  request present on `B`, `shift`, `IR`.
- `in_ready`  output  1  unit can accept a request.
- `IR`  input  1  fill bit shifted in at the MSB end (0 for SRL, `B[data_length-1]` for SRA; the caller drives it).
- `shift`  input  N  shift amount, 0..data_length-1.
- `B`  input  data_length  operand.
- `out_valid`  output  1  result on `H` is valid.
- `out_ready`  input  1  consumer accepts the result.
- `H`  output  data_length  result, equal to `B >> shift` with vacated MSBs filled with `IR`.

## Operation
- Internal registers:
  - `data_r` (data_length bits), `amt_r` (N bits), `fill_r` (1 bit).
  - Stage counter `stg` (N bits wide; counts 0..N-1).
  - State in {IDLE, SHIFT, DONE}.
- IDLE:
  - `in_ready`=1, `out_valid`=0.
  - On `in_valid`: load `data_r`←`B`, `amt_r`←`shift`, `fill_r`←`IR`, `stg`←0, then go to SHIFT.
- SHIFT:
  - `in_ready`=0, `out_valid`=0.
  - Each cycle with j=`stg`: if `amt_r[j]`, set `data_r` ← {2^j copies of `fill_r`, `data_r[data_length-1:2^j]`}; otherwise hold `data_r`.
  - If `stg`==N-1, go to DONE; otherwise `stg`←`stg`+1.
- DONE:
  - `out_valid`=1, `in_ready`=0, `H`=`data_r`.
  - On `out_ready`, go to IDLE.
- `H` is driven from `data_r` at all times. It is only meaningful while `out_valid`=1.
- Inputs are sampled only at the accepting edge. Changes to `B`/`shift`/`IR` afterwards have no effect.
- `in_valid` outside IDLE is ignored. It is neither queued nor dropped-with-error; the requester holds it until `in_ready`.
- `shift`=0 still traverses all N stages, and the result equals `B`.
- Stage order is fixed LSB stage first. The result is order-independent, but the bench checks `data_r` per stage only via the final `H`.

## Timing
- Reset (`rst`=1 at a rising edge):
  - state←IDLE, `stg`←0, `data_r`←0, `amt_r`←0, `fill_r`←0.
  - After that edge: `in_ready`=1, `out_valid`=0, `H`=0.
- `rst` has priority over every handshake in the same cycle.
- While `rst` is high, `in_ready` is forced to 0 combinationally.
- Reset during SHIFT or DONE aborts the operation. No `out_valid` pulse is produced for it.
- Latency: request accepted at edge E (`in_valid`&&`in_ready`). Stages are applied at edges E+1..E+N, and `out_valid` rises after edge E+N (N=5 for the default width).
- Result consumed at edge F (`out_valid`&&`out_ready`): `out_valid`=0 and `in_ready`=1 after F. The earliest next acceptance is edge F+1.
- Minimum initiation interval: N+2 cycles (5 shift cycles, 1 DONE cycle with `out_ready`=1, 1 IDLE cycle).
- Backpressure: while in DONE with `out_ready`=0, `out_valid` stays 1 and `H` stays stable indefinitely.
- `in_ready` and `out_valid` are functions of state (and `rst`) only. There are no combinational paths from `in_valid`/`out_ready`.

## Test plan
- Logical, maximum shift: `B`=0x80000000, `shift`=31, `IR`=0 → `out_valid` 5 cycles after acceptance, `H`=0x00000001.
- Arithmetic fill: `B`=0x80000000, `shift`=4, `IR`=1 → `H`=0xF8000000. Also `B`=0x7FFFFFF0, `shift`=4, `IR`=0 → `H`=0x07FFFFFF.
- Zero shift: `B`=0xDEADBEEF, `shift`=0 → `H`=0xDEADBEEF after the full 5-cycle latency.
- Backpressure:
  - `out_ready`=0 for 10 cycles after `out_valid` → `out_valid`=1 and `H` unchanged throughout, `in_ready`=0.
  - A second `in_valid` (`B`=0x12345678) during this window is ignored.
  - Release `out_ready` → IDLE next cycle, and the second request is then accepted.
- Reset mid-operation: assert `rst` one cycle at the 3rd SHIFT cycle → afterwards `in_ready`=1, `out_valid`=0, `H`=0. No result appears for that request.
- Back-to-back with random `B`/`shift`/`IR` (1000 ops, `out_ready`=1):
  - Each `H` matches the model `(B >> shift) | (IR ? ~({data_length{1'b1}} >> shift) : 0)`.
  - Acceptances are spaced exactly 7 cycles apart.
